// File: rtl/fc_pkg.sv
// Shared definitions for the FC datapath movers (read side and write-back side).
// Both movers use the same state encoding for their run/idle/done control, so
// firmware can sequence them identically.
//   state_e            : S_IDLE / S_RUN / S_DONE control states
//   IN_DATA_WIDTH_DEF  : default packed lane width (signed)
//   RWIDTH_DEF         : default core-array result width (signed)
//   LANES              : lanes packed per BRAM word
package fc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int IN_DATA_WIDTH_DEF = 16;
  localparam int RWIDTH_DEF        = 32;
  localparam int LANES             = 4;

endpackage

// File: rtl/result_writer_bram_if.sv
// Lane result stream from the fully-connected core array into the writer.
//   i_valid          : four lane results valid this cycle
//   i_result_0..3    : signed lane results, RWIDTH bits each
//   o_ready          : writer accepts a beat when i_valid && o_ready
// master = core array side, slave = result writer side.
interface result_writer_bram_if #(
  parameter int RWIDTH = 32
) ();

  logic                     i_valid;
  logic signed [RWIDTH-1:0] i_result_0;
  logic signed [RWIDTH-1:0] i_result_1;
  logic signed [RWIDTH-1:0] i_result_2;
  logic signed [RWIDTH-1:0] i_result_3;
  logic                     o_ready;

  modport master (
    output i_valid, i_result_0, i_result_1, i_result_2, i_result_3,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_result_0, i_result_1, i_result_2, i_result_3,
    output o_ready
  );

endinterface

// File: rtl/result_sat_lane.sv
// One lane of the write-back transform: optional ReLU, then signed saturation
// of an RWIDTH result down to IN_DATA_WIDTH.
//   din     : signed lane result
//   relu_en : clamp negative values to zero before saturating
//   dout    : saturated lane, IN_DATA_WIDTH bits two's complement
module result_sat_lane #(
  parameter int RWIDTH        = 32,
  parameter int IN_DATA_WIDTH = 16
) (
  input  logic signed [RWIDTH-1:0]        din,
  input  logic                            relu_en,
  output logic        [IN_DATA_WIDTH-1:0] dout
);

  localparam logic signed [RWIDTH-1:0] MAX_V =
    {{(RWIDTH-IN_DATA_WIDTH+1){1'b0}}, {(IN_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RWIDTH-1:0] MIN_V =
    {{(RWIDTH-IN_DATA_WIDTH+1){1'b1}}, {(IN_DATA_WIDTH-1){1'b0}}};

  logic signed [RWIDTH-1:0] v;

  always_comb begin
    v    = (relu_en && din[RWIDTH-1]) ? '0 : din;
    dout = v[IN_DATA_WIDTH-1:0];
    if (v > MAX_V) begin
      dout = {1'b0, {(IN_DATA_WIDTH-1){1'b1}}};
    end else if (v < MIN_V) begin
      dout = {1'b1, {(IN_DATA_WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/result_writer_bram.sv
// Write-back end of the FC datapath. Takes four signed lane results per beat,
// applies optional ReLU and saturation, packs them into one BRAM word (lane 0
// in the top slice) and writes consecutive words from a programmable base.
//   clk, reset_n      : clock, asynchronous active-low reset
//   i_run             : start pulse, honoured only in S_IDLE
//   i_num_cnt         : words to write (0 goes straight to S_DONE)
//   i_base_addr       : first BRAM address (wraps modulo 2^AWIDTH)
//   i_relu_en         : ReLU enable, captured with i_run
//   lane              : lane result stream (valid/ready + four results)
//   o_idle/o_write    : FSM in S_IDLE / S_RUN
//   o_done            : one-cycle pulse in S_DONE
//   o_err_drop        : sticky, a beat arrived while not ready
//   addr_b/ce_b/we_b/d_b/q_b : BRAM write port (q_b unused)
module result_writer_bram
  import fc_pkg::*;
#(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH        = 64,
  parameter int AWIDTH        = 12,
  parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
  parameter int RWIDTH        = RWIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_run,
  input  logic [CNT_BIT-1:0]  i_num_cnt,
  input  logic [AWIDTH-1:0]   i_base_addr,
  input  logic                i_relu_en,
  result_writer_bram_if.slave lane,
  output logic                o_idle,
  output logic                o_write,
  output logic                o_done,
  output logic                o_err_drop,
  output logic [AWIDTH-1:0]   addr_b,
  output logic                ce_b,
  output logic                we_b,
  output logic [DWIDTH-1:0]   d_b,
  input  logic [DWIDTH-1:0]   q_b
);

  state_e              state_q;
  logic [CNT_BIT-1:0]  num_cnt_q;
  logic [CNT_BIT-1:0]  wr_cnt_q;
  logic [AWIDTH-1:0]   base_q;
  logic                relu_q;

  logic                ready;
  logic                accept;
  logic                drop;
  logic                start;
  logic                last_beat;
  logic [DWIDTH-1:0]   packed_word;

  logic signed [RWIDTH-1:0]        lane_in  [LANES];
  logic        [IN_DATA_WIDTH-1:0] lane_out [LANES];

  logic unused_q_b;
  assign unused_q_b = ^q_b;

  assign ready     = (state_q == S_RUN);
  assign accept    = lane.i_valid && ready;
  assign drop      = lane.i_valid && !ready;
  assign start     = i_run && (state_q == S_IDLE);
  assign last_beat = (wr_cnt_q == num_cnt_q - CNT_BIT'(1));

  assign lane.o_ready = ready;
  assign o_idle       = (state_q == S_IDLE);
  assign o_write      = (state_q == S_RUN);
  assign o_done       = (state_q == S_DONE);

  assign lane_in[0] = lane.i_result_0;
  assign lane_in[1] = lane.i_result_1;
  assign lane_in[2] = lane.i_result_2;
  assign lane_in[3] = lane.i_result_3;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    result_sat_lane #(
      .RWIDTH        (RWIDTH),
      .IN_DATA_WIDTH (IN_DATA_WIDTH)
    ) u_sat (
      .din     (lane_in[g]),
      .relu_en (relu_q),
      .dout    (lane_out[g])
    );
  end

  assign packed_word = {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};

  // The last beat's BRAM write lands in the S_DONE cycle, so o_done and the
  // final word commit on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      num_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      base_q     <= '0;
      relu_q     <= 1'b0;
      o_err_drop <= 1'b0;
      addr_b     <= '0;
      ce_b       <= 1'b0;
      we_b       <= 1'b0;
      d_b        <= '0;
    end else begin
      ce_b <= 1'b0;
      we_b <= 1'b0;

      // A drop in the same cycle as the start wins over the clear.
      if (drop) begin
        o_err_drop <= 1'b1;
      end else if (start) begin
        o_err_drop <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (i_run) begin
            num_cnt_q <= i_num_cnt;
            base_q    <= i_base_addr;
            relu_q    <= i_relu_en;
            wr_cnt_q  <= '0;
            state_q   <= (i_num_cnt == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            ce_b   <= 1'b1;
            we_b   <= 1'b1;
            addr_b <= base_q + AWIDTH'(wr_cnt_q);
            d_b    <= packed_word;
            if (last_beat) begin
              wr_cnt_q <= '0;
              state_q  <= S_DONE;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_BIT'(1);
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writer_bram.sv
module tb_result_writer_bram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_run = 1'b0;
  logic [30:0] i_num_cnt = '0;
  logic [11:0] i_base_addr = '0;
  logic        i_relu_en = 1'b0;
  logic        o_idle, o_write, o_done, o_err_drop;
  logic [11:0] addr_b;
  logic        ce_b, we_b;
  logic [63:0] d_b;
  logic [63:0] q_b = '0;

  result_writer_bram_if #(.RWIDTH(32)) lane_if ();

  result_writer_bram #(
    .CNT_BIT       (31),
    .DWIDTH        (64),
    .AWIDTH        (12),
    .IN_DATA_WIDTH (16),
    .RWIDTH        (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (i_run),
    .i_num_cnt   (i_num_cnt),
    .i_base_addr (i_base_addr),
    .i_relu_en   (i_relu_en),
    .lane        (lane_if),
    .o_idle      (o_idle),
    .o_write     (o_write),
    .o_done      (o_done),
    .o_err_drop  (o_err_drop),
    .addr_b      (addr_b),
    .ce_b        (ce_b),
    .we_b        (we_b),
    .d_b         (d_b),
    .q_b         (q_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference lane transform: ReLU, then clamp to signed 16-bit range.
  function automatic logic [15:0] ref_lane(input int v, input bit relu);
    int x;
    logic [31:0] b;
    x = v;
    if (relu && x < 0) x = 0;
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
    b = x;
    return b[15:0];
  endfunction

  function automatic logic [63:0] ref_word(input int l0, l1, l2, l3, input bit relu);
    return {ref_lane(l0, relu), ref_lane(l1, relu), ref_lane(l2, relu), ref_lane(l3, relu)};
  endfunction

  function automatic logic [11:0] ref_addr(input logic [11:0] base, input int k);
    int a;
    logic [31:0] b;
    a = (int'(base) + k) % 4096;
    b = a;
    return b[11:0];
  endfunction

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 200)) - 100;
      1:       return int'($urandom());
      2:       return 32767 + int'($urandom_range(0, 4)) - 2;
      default: return -32768 + int'($urandom_range(0, 4)) - 2;
    endcase
  endfunction

  // Monitor: every BRAM write must match the head of the expected queue,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    if (reset_n && (ce_b || we_b)) begin
      check("write_queued", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("ce_we", {62'd0, ce_b, we_b}, 64'd3);
        check("addr_b", 64'(addr_b), 64'(e.addr));
        check("d_b", d_b, e.data);
        check("write_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    lane_if.i_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run(input logic [11:0] base, input int num, input bit relu, input bit with_valid);
    i_run = 1'b1;
    i_num_cnt = 31'(num);
    i_base_addr = base;
    i_relu_en = relu;
    lane_if.i_valid = with_valid;
    @(posedge clk); #1;
    i_run = 1'b0;
    lane_if.i_valid = 1'b0;
    check("ready_after_run", 64'(lane_if.o_ready), 64'(num != 0));
    check("done_after_run", 64'(o_done), 64'(num == 0));
  endtask

  task automatic send_beat(input logic [11:0] base, input int k, input bit relu,
                           input int l0, l1, l2, l3);
    lane_if.i_valid = 1'b1;
    lane_if.i_result_0 = l0;
    lane_if.i_result_1 = l1;
    lane_if.i_result_2 = l2;
    lane_if.i_result_3 = l3;
    check("ready_in_run", 64'(lane_if.o_ready), 64'(1));
    exp_q.push_back('{addr: ref_addr(base, k), data: ref_word(l0, l1, l2, l3, relu), cyc: cyc + 1});
    @(posedge clk); #1;
  endtask

  // Called right after the final accept edge.
  task automatic finish_run();
    lane_if.i_valid = 1'b0;
    check("done_pulse", 64'(o_done), 64'(1));
    check("ready_in_done", 64'(lane_if.o_ready), 64'(0));
    @(posedge clk); #1;
    check("done_cleared", 64'(o_done), 64'(0));
    check("idle_after_done", 64'(o_idle), 64'(1));
  endtask

  task automatic rand_run(input logic [11:0] base, input int num, input bit relu, input int max_gap);
    start_run(base, num, relu, 1'b0);
    for (int k = 0; k < num; k++) begin
      if (k != 0 && max_gap != 0) idle($urandom_range(0, max_gap));
      send_beat(base, k, relu, rand_lane(), rand_lane(), rand_lane(), rand_lane());
    end
    if (num != 0) finish_run();
    else idle(1);
  endtask

  initial begin
    lane_if.i_valid = 1'b0;
    lane_if.i_result_0 = 0;
    lane_if.i_result_1 = 0;
    lane_if.i_result_2 = 0;
    lane_if.i_result_3 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", 64'(o_idle), 64'(1));
    check("rst_ready", 64'(lane_if.o_ready), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_err", 64'(o_err_drop), 64'(0));
    check("rst_bram", {addr_b, ce_b, we_b, d_b[49:0]}, 64'd0);
    check("rst_d_b", d_b, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic run, lanes (1,2,3,4)+k
    start_run(12'h010, 4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(12'h010, k, 1'b0, 1 + k, 2 + k, 3 + k, 4 + k);
    finish_run();

    // Saturation and ReLU
    start_run(12'h040, 1, 1'b0, 1'b0);
    send_beat(12'h040, 0, 1'b0, 40000, -40000, 32767, -32768);
    finish_run();
    start_run(12'h050, 1, 1'b1, 1'b0);
    send_beat(12'h050, 0, 1'b1, -5, 7, -70000, 70000);
    finish_run();

    // Gapped valid: accepts on cycles 0, 3, 4
    start_run(12'h200, 3, 1'b0, 1'b0);
    send_beat(12'h200, 0, 1'b0, 11, 12, 13, 14);
    idle(2);
    send_beat(12'h200, 1, 1'b0, 21, 22, 23, 24);
    send_beat(12'h200, 2, 1'b0, 31, 32, 33, 34);
    finish_run();

    // num=0 and address wrap
    start_run(12'h300, 0, 1'b0, 1'b0);
    idle(1);
    check("idle_after_zero", 64'(o_idle), 64'(1));
    start_run(12'hFFE, 3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_beat(12'hFFE, k, 1'b0, -k, k * 1000, 5, -6);
    finish_run();

    // Drop error handling
    check("err_clear", 64'(o_err_drop), 64'(0));
    lane_if.i_valid = 1'b1;
    @(posedge clk); #1;
    lane_if.i_valid = 1'b0;
    check("err_set_idle", 64'(o_err_drop), 64'(1));
    start_run(12'h000, 0, 1'b0, 1'b0);
    check("err_cleared_by_run", 64'(o_err_drop), 64'(0));
    idle(1);
    start_run(12'h400, 1, 1'b0, 1'b1);
    check("err_set_with_run", 64'(o_err_drop), 64'(1));
    send_beat(12'h400, 0, 1'b0, 1, 1, 1, 1);
    finish_run();
    check("err_sticky", 64'(o_err_drop), 64'(1));
    start_run(12'h410, 1, 1'b0, 1'b0);
    check("err_cleared_again", 64'(o_err_drop), 64'(0));
    send_beat(12'h410, 0, 1'b0, 9, 8, 7, 6);
    finish_run();

    // Reset mid-run after 2 of 5 beats
    start_run(12'h100, 5, 1'b0, 1'b0);
    send_beat(12'h100, 0, 1'b0, 100, 200, 300, 400);
    send_beat(12'h100, 1, 1'b0, 101, 201, 301, 401);
    idle(1);
    reset_n = 1'b0;
    #2;
    check("midrst_idle", 64'(o_idle), 64'(1));
    check("midrst_ready", 64'(lane_if.o_ready), 64'(0));
    check("midrst_outs", {o_write, o_done, o_err_drop, ce_b, we_b, 47'd0, addr_b}, 64'd0);
    check("midrst_d_b", d_b, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    start_run(12'h020, 2, 1'b0, 1'b0);
    send_beat(12'h020, 0, 1'b0, -1, -2, -3, -4);
    send_beat(12'h020, 1, 1'b0, 5, 6, 7, 8);
    finish_run();

    // Randomised runs
    for (int r = 0; r < 25; r++) begin
      logic [11:0] b;
      b = 12'($urandom());
      rand_run(b, $urandom_range(0, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_err", 64'(o_err_drop), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
